// File: rtl/aes_sub_bytes_seq.sv
// Serialised AES SubBytes: one shared s_box walks the 16 state bytes, one byte per cycle.
// Latency NUM_BYTES+SBOX_LAT cycles from accept to out_valid; holds result in DONE until out_ready.
module aes_sub_bytes_seq #(
    parameter int NUM_BYTES = 16,
    parameter int SBOX_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_state,
    output logic                   busy
);
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int DW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [8*NUM_BYTES-1:0] hold_q;
    logic [8*NUM_BYTES-1:0] out_q;
    logic [IW-1:0]          idx_q;
    logic [DW-1:0]          drain_q;
    logic                   vld_q  [SBOX_LAT];
    logic [IW-1:0]          didx_q [SBOX_LAT];
    logic [7:0]             sub_q  [SBOX_LAT];
    logic [7:0]             in_byte_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r  = 8'h01;
        logic [7:0] sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Byte 0 lives in the most significant lane.
    assign in_byte_d = hold_q[8*(NUM_BYTES-1-int'(idx_q)) +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            for (int k = 0; k < SBOX_LAT; k++) begin
                vld_q[k]  <= 1'b0;
                didx_q[k] <= '0;
                sub_q[k]  <= '0;
            end
        end else begin
            vld_q[0]  <= (state_q == RUN);
            didx_q[0] <= idx_q;
            sub_q[0]  <= sbox(in_byte_d);
            for (int k = 1; k < SBOX_LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                didx_q[k] <= didx_q[k-1];
                sub_q[k]  <= sub_q[k-1];
            end
            if (vld_q[SBOX_LAT-1])
                out_q[8*(NUM_BYTES-1-int'(didx_q[SBOX_LAT-1])) +: 8] <= sub_q[SBOX_LAT-1];

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        hold_q  <= in_state;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_BYTES-1)) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + DW'(1);
                    if (drain_q == DW'(SBOX_LAT-1)) state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign out_state = out_q;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: known-answer vectors, latency, backpressure, reset abort.
module tb_aes_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] v_fips_in, v_fips_out, v_zero_in, v_zero_out;
    logic [127:0] v_9a_in, v_9a_out, v_mix_in, v_mix_out;

    aes_sub_bytes_seq #(.NUM_BYTES(16), .SBOX_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, accept one state, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [127:0] st, input logic [127:0] exp,
                          input bit scramble);
        int cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq({tag, "_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, 128'(busy), 128'd1);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            if (scramble) in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            cnt++;
        end
        check_eq({tag, "_latency"}, 128'(cnt), 128'd17);
        check_eq({tag, "_data"}, out_state, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, {126'd0, out_valid, in_ready}, 128'b01);
    endtask

    initial begin
        logic [127:0] held;
        int low;
        int cnt;
        v_fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        v_fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
        v_zero_in  = '0;
        v_zero_out = {16{8'h63}};
        v_9a_in    = {16{8'h9a}};
        v_9a_out   = {16{8'hb8}};
        v_mix_in   = {8'h9a, 8'h9f, {13{8'h00}}, 8'h06};
        v_mix_out  = {8'hb8, 8'hdb, {13{8'h63}}, 8'h6f};

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_out_state", out_state, 128'd0);

        run_op("fips", v_fips_in, v_fips_out, 1'b0);
        run_op("zero", v_zero_in, v_zero_out, 1'b0);
        run_op("all9a", v_9a_in, v_9a_out, 1'b0);
        run_op("mix", v_mix_in, v_mix_out, 1'b0);
        run_op("scramble", v_fips_in, v_fips_out, 1'b1);

        // Backpressure: result must hold while a new state is offered and refused.
        in_valid = 1'b1;
        in_state = v_fips_in;
        tick();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        held = out_state;
        check_eq("bp_first", held, v_fips_out);
        in_state = v_9a_in;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            tick();
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_hold", out_state, v_fips_out);
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_release", {126'd0, out_valid, in_ready}, 128'b01);

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        in_state = v_zero_in;
        out_ready = 1'b1;
        tick();
        low = 0;
        cnt = 0;
        while (!in_ready && cnt < 60) begin
            low++;
            if (out_valid) begin
                check_eq("b2b_first", out_state, v_zero_out);
                in_state = v_mix_in;
            end
            tick();
            cnt++;
        end
        check_eq("b2b_gap", 128'(low), 128'd18);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check_eq("b2b_latency", 128'(cnt), 128'd17);
        check_eq("b2b_second", out_state, v_mix_out);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while idx==7 aborts the operation.
        in_valid = 1'b1;
        in_state = v_9a_in;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("abort_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_state", {125'd0, in_ready, out_valid, busy}, 128'b100);
        check_eq("abort_out", out_state, 128'd0);
        run_op("after_abort", v_fips_in, v_fips_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
